// File: rtl/par2ser_lanes.sv
`default_nettype none
// ============================================================================
// Module   : par2ser_lanes
// Purpose  : Multi-lane parallel-to-serial converter with a one-word holding
//            register, shared bit counter and idle-symbol fill.
// Revision : 1.0
// ============================================================================
module par2ser_lanes #(
    parameter int               WIDTH     = 8,
    parameter int               LANES     = 1,
    parameter logic [WIDTH-1:0] IDLE      = 8'hBC,
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic [LANES*WIDTH-1:0] data_in,
    output logic                   in_ready,
    output logic [LANES-1:0]       data_out,
    output logic                   word_start,
    output logic                   is_data
);

    localparam int                   c_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0]      c_LAST     = c_CW'(WIDTH - 1);
    localparam logic [LANES*WIDTH-1:0] c_IDLE_ALL = {LANES{IDLE}};

    logic [c_CW-1:0]        r_cnt;
    logic [LANES*WIDTH-1:0] r_hold;
    logic                   r_hold_full;
    logic [LANES*WIDTH-1:0] r_shift;
    logic                   r_cur_is_data;

    logic                   w_at_end;
    logic                   w_accept;
    logic                   w_load;
    logic [c_CW-1:0]        w_idx;
    logic [LANES-1:0]       w_bits;

    assign w_at_end = (r_cnt == c_LAST);
    assign in_ready = reset && (!r_hold_full || w_at_end);
    assign w_accept = valid_in && in_ready;
    // A word is available at the boundary if it is already held or arrives now
    assign w_load   = r_hold_full || w_accept;
    assign w_idx    = MSB_FIRST ? (c_LAST - r_cnt) : r_cnt;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [WIDTH-1:0] w_lane_word;
            assign w_lane_word = r_shift[k*WIDTH +: WIDTH];
            assign w_bits[k]   = w_lane_word[w_idx];
        end
    endgenerate

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_shift       <= c_IDLE_ALL;
            r_cur_is_data <= 1'b0;
            data_out      <= '0;
            word_start    <= 1'b0;
            is_data       <= 1'b0;
        end else begin
            data_out   <= w_bits;
            word_start <= (r_cnt == '0);
            is_data    <= r_cur_is_data;

            if (w_accept) begin
                r_hold <= data_in;
            end

            if (w_at_end) begin
                r_cnt <= '0;
                if (w_load) begin
                    r_shift       <= r_hold_full ? r_hold : data_in;
                    r_cur_is_data <= 1'b1;
                end else begin
                    r_shift       <= c_IDLE_ALL;
                    r_cur_is_data <= 1'b0;
                end
                // Hold stays full only when a new word replaces the one that drained
                r_hold_full <= w_accept && r_hold_full;
            end else begin
                r_cnt       <= r_cnt + c_CW'(1);
                r_hold_full <= r_hold_full || w_accept;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/par2ser_lanes.md
Name: par2ser_lanes

Overview:
Parametrised multi-lane parallel-to-serial converter for the clk_32f serial domain. It shifts LANES independent WIDTH-bit words out on LANES serial lines, all sharing one bit counter. Input uses a valid/ready handshake backed by a one-word holding register. When no data is pending, each lane transmits a programmable idle/comma symbol.

Parameters:
WIDTH, 8, bits per word per lane (>=2)
LANES, 1, number of parallel serial lanes (>=1)
IDLE, 8'hBC, WIDTH-bit idle symbol sent on every lane when no data is pending
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first

Ports:
clk_32f  input  1  serial bit clock
reset  input  1  synchronous, active-low reset
valid_in  input  1  data_in holds a word set for all lanes
data_in  input  LANES*WIDTH  lane k uses bits [k*WIDTH +: WIDTH]
in_ready  output  1  combinational; block accepts data_in this cycle
data_out  output  LANES  registered serial bit per lane
word_start  output  1  registered; high with the first bit of every word (data or idle)
is_data  output  1  registered; high while data_out carries a data word, low for idle

Behaviour:
- Reset: clock clk_32f; reset is synchronous, active-low. Sampled at posedge; reset==0 takes priority over everything.
- Reset values: bit counter=0; shift word per lane=IDLE; holding register empty; cur_is_data=0; data_out=0; word_start=0; is_data=0.
- in_ready = reset && (!hold_full || cnt==WIDTH-1). It is 0 during reset.
- Accept: at posedge, if valid_in && in_ready, then hold<=data_in and hold_full<=1. data_in is ignored when not accepted; the source must keep it stable until accepted.
- Shift, at every posedge with reset==1:
  - Lane k drives data_out[k] <= shift_k[idx].
  - idx = WIDTH-1-cnt if MSB_FIRST, otherwise idx = cnt.
  - word_start <= (cnt==0); is_data <= cur_is_data.
- Word boundary (cnt==WIDTH-1):
  - cnt <= 0.
  - If hold_full, or an accept happens in the same cycle with the hold empty: shift words <= the pending word (hold, else data_in), and cur_is_data <= 1.
  - Otherwise: shift words <= IDLE on all lanes, and cur_is_data <= 0.
  - hold_full <= 1 only if a new word was accepted in this cycle while a previous word drained into the shift register; otherwise hold_full <= 0.
- Otherwise: cnt <= cnt+1. Shift words and cur_is_data are unchanged.
- Latency: a word accepted at boundary edge E starts on data_out at edge E+1. A word accepted mid-word starts at the edge after the next boundary. Bits stream continuously, with no gaps between words.
- Simultaneous accept + drain at a boundary:
  - The old hold word moves to the shift register.
  - The new word enters hold.
  - Nothing is lost or duplicated.
- Full: while hold_full and cnt!=WIDTH-1, in_ready=0.
- Reset mid-word: the current word, the held word and the counter are discarded. After release, the first edge emits bit idx(0) of IDLE with word_start=1.
- All lanes share cnt, word_start and is_data. Lane words are never skewed relative to each other.

Test Plan:
- Defaults, reset low 3 cycles then high, valid_in=0 -> data_out repeats 1,0,1,1,1,1,0,0; word_start high every 8th cycle starting at the first post-reset edge; is_data=0; in_ready=1.
- Single word 8'hA5 held valid until accepted -> after the current idle word completes: 1,0,1,0,0,1,0,1 with is_data=1, then idle BC resumes with is_data=0.
- Back-to-back 8'h12, 8'h34, 8'h56 with valid_in held high -> the three words stream contiguously; in_ready drops while hold is full and pulses high at each cnt==7; no word lost or repeated.
- MSB_FIRST=0, word 8'h01 -> 1,0,0,0,0,0,0,0; the idle word is sent as 0,0,1,1,1,1,0,1.
- LANES=4, WIDTH=10, IDLE=10'h17C, data_in={10'h3FF,10'h000,10'h2AA,10'h155} -> each lane emits its own slice in the same 10-cycle window; word_start is shared.
- Reset asserted at cnt=4 with hold full -> outputs go to 0 and in_ready=0; after release the line carries IDLE from bit idx(0); the held word is never transmitted.
